// File: rtl/prize_score_manager.sv
// prize_score_manager: turns per-pixel prize/coin collision strobes into one scoring event per frame,
// keeps the BCD score and prizes remaining, and sequences level advance and game completion.
`default_nettype none

module prize_score_manager #(
  parameter int NUM_LEVELS   = 2,
  parameter int PRIZES_L0    = 1,
  parameter int PRIZES_L1    = 10,
  parameter int PRIZES_L2    = 10,
  parameter int PRIZES_L3    = 10,
  parameter int PTS_REGU     = 1,
  parameter int PTS_SPECIAL  = 5,
  parameter int CLEAR_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        prize_collision,
  input  logic [2:0]  prize_type,
  input  logic        coin_step_collision,
  input  logic [3:0]  HitEdgeCode,
  input  logic        bumpy_diedN,
  output logic [2:0]  lvl,
  output logic        next_lvl,
  output logic [6:0]  prizes_left,
  output logic [15:0] score_bcd,
  output logic        game_won
);

  typedef enum logic [1:0] {PLAY = 2'd0, LVL_CLEAR = 2'd1, WON = 2'd2} state_t;

  localparam logic [3:0] EDGE_TOP = 4'b0100;

  state_t      state;
  logic        p_pend;
  logic        c_pend;
  logic [2:0]  p_type;
  logic [7:0]  frame_cnt;

  logic        p_hit;
  logic        c_hit;
  logic [3:0]  pts;
  logic [15:0] score_next;
  logic [7:0]  count_sum;
  logic [6:0]  prizes_next;
  logic        clear_done;
  logic        last_level;

  function automatic logic [6:0] level_prizes(input logic [2:0] l);
    case (l)
      3'd0:    return 7'(PRIZES_L0);
      3'd1:    return 7'(PRIZES_L1);
      3'd2:    return 7'(PRIZES_L2);
      default: return 7'(PRIZES_L3);
    endcase
  endfunction

  // Ripple-carry BCD add of a tens increment and a ones increment; overflow past 9999 clamps.
  function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [3:0] tens_inc,
                                          input logic ones_inc);
    logic [4:0]  d;
    logic        carry;
    logic [15:0] r;
    d = {1'b0, s[3:0]} + {4'b0, ones_inc};
    carry = (d > 5'd9);
    if (carry) d = d - 5'd10;
    r[3:0] = d[3:0];
    d = {1'b0, s[7:4]} + {1'b0, tens_inc} + {4'b0, carry};
    carry = (d > 5'd9);
    if (carry) d = d - 5'd10;
    r[7:4] = d[3:0];
    d = {1'b0, s[11:8]} + {4'b0, carry};
    carry = (d > 5'd9);
    if (carry) d = d - 5'd10;
    r[11:8] = d[3:0];
    d = {1'b0, s[15:12]} + {4'b0, carry};
    carry = (d > 5'd9);
    if (carry) d = d - 5'd10;
    r[15:12] = d[3:0];
    return carry ? 16'h9999 : r;
  endfunction

  always_comb begin
    p_hit       = prize_collision && (prize_type != 3'b000);
    c_hit       = coin_step_collision && (HitEdgeCode == EDGE_TOP);
    pts         = (p_type == 3'b001) ? 4'(PTS_REGU) : 4'(PTS_SPECIAL);
    score_next  = bcd_add(score_bcd, p_pend ? pts : 4'd0, c_pend);
    count_sum   = {1'b0, prizes_left} - {7'b0, (p_pend && (prizes_left != 7'd0))} + {7'b0, c_pend};
    prizes_next = (count_sum > 8'd127) ? 7'd127 : count_sum[6:0];
    clear_done  = ((frame_cnt + 8'd1) == 8'(CLEAR_FRAMES));
    last_level  = (lvl == 3'(NUM_LEVELS - 1));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= PLAY;
      lvl         <= 3'd0;
      next_lvl    <= 1'b0;
      prizes_left <= 7'(PRIZES_L0);
      score_bcd   <= 16'h0000;
      game_won    <= 1'b0;
      p_pend      <= 1'b0;
      c_pend      <= 1'b0;
      p_type      <= 3'b000;
      frame_cnt   <= 8'd0;
    end else begin
      next_lvl <= 1'b0;
      if (!bumpy_diedN && (state != WON)) begin
        p_pend      <= 1'b0;
        c_pend      <= 1'b0;
        frame_cnt   <= 8'd0;
        prizes_left <= level_prizes(lvl);
        state       <= PLAY;
      end else begin
        case (state)
          PLAY: begin
            if (startOfFrame) begin
              score_bcd   <= score_next;
              prizes_left <= prizes_next;
              // Events seen on the commit cycle itself belong to the following frame.
              p_pend <= p_hit;
              c_pend <= c_hit;
              if (p_hit) p_type <= prize_type;
              if (prizes_next == 7'd0) begin
                state     <= LVL_CLEAR;
                frame_cnt <= 8'd0;
                p_pend    <= 1'b0;
                c_pend    <= 1'b0;
              end
            end else begin
              if (p_hit && !p_pend) begin
                p_pend <= 1'b1;
                p_type <= prize_type;
              end
              if (c_hit) c_pend <= 1'b1;
            end
          end
          LVL_CLEAR: begin
            if (startOfFrame) begin
              if (clear_done) begin
                frame_cnt <= 8'd0;
                if (last_level) begin
                  state    <= WON;
                  game_won <= 1'b1;
                end else begin
                  lvl         <= lvl + 3'd1;
                  next_lvl    <= 1'b1;
                  prizes_left <= level_prizes(lvl + 3'd1);
                  state       <= PLAY;
                end
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          WON: ;
          default: state <= PLAY;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prize_score_manager.sv
// Directed self-checking bench for prize_score_manager (two levels, three-frame clear delay).
`default_nettype none

module tb_prize_score_manager;

  localparam logic [3:0] TOP  = 4'b0100;
  localparam logic [3:0] SIDE = 4'b0010;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        prize_collision = 1'b0;
  logic [2:0]  prize_type = 3'b000;
  logic        coin_step_collision = 1'b0;
  logic [3:0]  HitEdgeCode = 4'b0000;
  logic        bumpy_diedN = 1'b1;
  logic [2:0]  lvl;
  logic        next_lvl;
  logic [6:0]  prizes_left;
  logic [15:0] score_bcd;
  logic        game_won;

  int n_checks = 0;
  int n_fail   = 0;

  prize_score_manager #(.NUM_LEVELS(2), .PRIZES_L0(1), .PRIZES_L1(10), .CLEAR_FRAMES(3)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .prize_collision(prize_collision),
    .prize_type(prize_type), .coin_step_collision(coin_step_collision), .HitEdgeCode(HitEdgeCode),
    .bumpy_diedN(bumpy_diedN), .lvl(lvl), .next_lvl(next_lvl), .prizes_left(prizes_left),
    .score_bcd(score_bcd), .game_won(game_won)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One latch cycle with the given collisions, then a startOfFrame cycle with collisions idle.
  task automatic do_frame(input logic p, input logic [2:0] t, input logic c, input logic [3:0] e);
    prize_collision = p; prize_type = t; coin_step_collision = c; HitEdgeCode = e;
    tick;
    prize_collision = 1'b0; prize_type = 3'b000; coin_step_collision = 1'b0; HitEdgeCode = 4'b0000;
    startOfFrame = 1'b1;
    tick;
    startOfFrame = 1'b0;
  endtask

  task automatic sof_pulse;
    startOfFrame = 1'b1;
    tick;
    startOfFrame = 1'b0;
  endtask

  task automatic apply_reset;
    resetN = 1'b0;
    tick; tick;
    resetN = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    apply_reset;
    n_checks++; if (lvl !== 3'd0) begin n_fail++; $display("FAIL reset_lvl got %0d exp 0", lvl); end
    n_checks++; if (next_lvl !== 1'b0) begin n_fail++; $display("FAIL reset_next_lvl got %b exp 0", next_lvl); end
    n_checks++; if (prizes_left !== 7'd1) begin n_fail++; $display("FAIL reset_prizes got %0d exp 1", prizes_left); end
    n_checks++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_score got %h exp 0000", score_bcd); end
    n_checks++; if (game_won !== 1'b0) begin n_fail++; $display("FAIL reset_game_won got %b exp 0", game_won); end
  endtask

  task automatic test_level0_prize;
    prize_collision = 1'b1; prize_type = 3'b001;
    for (int i = 0; i < 200; i++) tick;
    prize_collision = 1'b0; prize_type = 3'b000;
    n_checks++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL l0_precommit_score got %h exp 0000", score_bcd); end
    sof_pulse;
    n_checks++; if (score_bcd !== 16'h0010) begin n_fail++; $display("FAIL l0_score got %h exp 0010", score_bcd); end
    n_checks++; if (prizes_left !== 7'd0) begin n_fail++; $display("FAIL l0_prizes got %0d exp 0", prizes_left); end
  endtask

  task automatic test_level_advance;
    for (int i = 1; i <= 2; i++) begin
      coin_step_collision = 1'b1; HitEdgeCode = TOP;
      tick;
      coin_step_collision = 1'b0; HitEdgeCode = 4'b0000;
      sof_pulse;
      n_checks++; if (lvl !== 3'd0 || next_lvl !== 1'b0) begin n_fail++; $display("FAIL clear_wait%0d lvl %0d next %b exp 0 0", i, lvl, next_lvl); end
      n_checks++; if (prizes_left !== 7'd0 || score_bcd !== 16'h0010) begin n_fail++; $display("FAIL clear_ignore%0d prizes %0d score %h exp 0 0010", i, prizes_left, score_bcd); end
    end
    sof_pulse;
    n_checks++; if (next_lvl !== 1'b1) begin n_fail++; $display("FAIL adv_next_lvl got %b exp 1", next_lvl); end
    n_checks++; if (lvl !== 3'd1) begin n_fail++; $display("FAIL adv_lvl got %0d exp 1", lvl); end
    n_checks++; if (prizes_left !== 7'd10) begin n_fail++; $display("FAIL adv_prizes got %0d exp 10", prizes_left); end
    tick;
    n_checks++; if (next_lvl !== 1'b0) begin n_fail++; $display("FAIL adv_pulse_width next_lvl got %b exp 0", next_lvl); end
  endtask

  task automatic test_prize_and_coin;
    for (int i = 0; i < 9; i++) do_frame(1'b1, 3'b001, 1'b0, 4'b0000);
    n_checks++; if (score_bcd !== 16'h0100 || prizes_left !== 7'd1) begin n_fail++; $display("FAIL l1_regular score %h prizes %0d exp 0100 1", score_bcd, prizes_left); end
    do_frame(1'b1, 3'b010, 1'b1, TOP);
    n_checks++; if (score_bcd !== 16'h0151) begin n_fail++; $display("FAIL both_score got %h exp 0151", score_bcd); end
    n_checks++; if (prizes_left !== 7'd1) begin n_fail++; $display("FAIL both_prizes got %0d exp 1", prizes_left); end
    do_frame(1'b0, 3'b000, 1'b1, SIDE);
    n_checks++; if (score_bcd !== 16'h0151 || prizes_left !== 7'd1) begin n_fail++; $display("FAIL side_coin score %h prizes %0d exp 0151 1", score_bcd, prizes_left); end
    do_frame(1'b0, 3'b000, 1'b1, TOP);
    n_checks++; if (score_bcd !== 16'h0152 || prizes_left !== 7'd2) begin n_fail++; $display("FAIL top_coin score %h prizes %0d exp 0152 2", score_bcd, prizes_left); end
  endtask

  task automatic test_death;
    prize_collision = 1'b1; prize_type = 3'b001;
    tick;
    prize_collision = 1'b0; prize_type = 3'b000;
    startOfFrame = 1'b1; bumpy_diedN = 1'b0;
    tick;
    startOfFrame = 1'b0; bumpy_diedN = 1'b1;
    n_checks++; if (prizes_left !== 7'd10) begin n_fail++; $display("FAIL death_prizes got %0d exp 10", prizes_left); end
    n_checks++; if (score_bcd !== 16'h0152) begin n_fail++; $display("FAIL death_score got %h exp 0152", score_bcd); end
    n_checks++; if (next_lvl !== 1'b0 || lvl !== 3'd1) begin n_fail++; $display("FAIL death_lvl next %b lvl %0d exp 0 1", next_lvl, lvl); end
    sof_pulse;
    n_checks++; if (score_bcd !== 16'h0152 || prizes_left !== 7'd10) begin n_fail++; $display("FAIL death_pend_cleared score %h prizes %0d exp 0152 10", score_bcd, prizes_left); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 192; i++) do_frame(1'b1, 3'b010, 1'b1, TOP);
    n_checks++; if (score_bcd !== 16'h9944 || prizes_left !== 7'd10) begin n_fail++; $display("FAIL ripple score %h prizes %0d exp 9944 10", score_bcd, prizes_left); end
    for (int i = 0; i < 46; i++) do_frame(1'b0, 3'b000, 1'b1, TOP);
    n_checks++; if (score_bcd !== 16'h9990 || prizes_left !== 7'd56) begin n_fail++; $display("FAIL preset score %h prizes %0d exp 9990 56", score_bcd, prizes_left); end
    do_frame(1'b1, 3'b010, 1'b0, 4'b0000);
    n_checks++; if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL score_sat got %h exp 9999", score_bcd); end
    n_checks++; if (prizes_left !== 7'd55) begin n_fail++; $display("FAIL score_sat_prizes got %0d exp 55", prizes_left); end
    for (int i = 0; i < 128; i++) do_frame(1'b0, 3'b000, 1'b1, TOP);
    n_checks++; if (prizes_left !== 7'd127) begin n_fail++; $display("FAIL prizes_sat got %0d exp 127", prizes_left); end
    n_checks++; if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL score_hold got %h exp 9999", score_bcd); end
  endtask

  task automatic test_win;
    apply_reset;
    do_frame(1'b1, 3'b001, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) sof_pulse;
    n_checks++; if (lvl !== 3'd1 || prizes_left !== 7'd10) begin n_fail++; $display("FAIL win_setup lvl %0d prizes %0d exp 1 10", lvl, prizes_left); end
    for (int i = 0; i < 10; i++) do_frame(1'b1, 3'b001, 1'b0, 4'b0000);
    n_checks++; if (score_bcd !== 16'h0110 || prizes_left !== 7'd0) begin n_fail++; $display("FAIL win_cleared score %h prizes %0d exp 0110 0", score_bcd, prizes_left); end
    sof_pulse; sof_pulse;
    n_checks++; if (game_won !== 1'b0) begin n_fail++; $display("FAIL win_early got %b exp 0", game_won); end
    sof_pulse;
    n_checks++; if (game_won !== 1'b1) begin n_fail++; $display("FAIL game_won got %b exp 1", game_won); end
    n_checks++; if (lvl !== 3'd1 || next_lvl !== 1'b0) begin n_fail++; $display("FAIL win_lvl lvl %0d next %b exp 1 0", lvl, next_lvl); end
    do_frame(1'b1, 3'b010, 1'b1, TOP);
    n_checks++; if (score_bcd !== 16'h0110 || prizes_left !== 7'd0) begin n_fail++; $display("FAIL win_frozen score %h prizes %0d exp 0110 0", score_bcd, prizes_left); end
    bumpy_diedN = 1'b0;
    tick;
    bumpy_diedN = 1'b1;
    n_checks++; if (prizes_left !== 7'd0 || game_won !== 1'b1) begin n_fail++; $display("FAIL win_death prizes %0d won %b exp 0 1", prizes_left, game_won); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    prize_collision = 1'b1; prize_type = 3'b010;
    resetN = 1'b0;
    #1;
    n_checks++; if (lvl !== 3'd0 || next_lvl !== 1'b0) begin n_fail++; $display("FAIL async_lvl lvl %0d next %b exp 0 0", lvl, next_lvl); end
    n_checks++; if (prizes_left !== 7'd1 || score_bcd !== 16'h0000) begin n_fail++; $display("FAIL async_counts prizes %0d score %h exp 1 0000", prizes_left, score_bcd); end
    n_checks++; if (game_won !== 1'b0) begin n_fail++; $display("FAIL async_game_won got %b exp 0", game_won); end
    prize_collision = 1'b0; prize_type = 3'b000;
    tick;
    resetN = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_level0_prize;
    test_level_advance;
    test_prize_and_coin;
    test_death;
    test_saturation;
    test_win;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
